// File: rtl/layer_mac_sequencer.sv
// ---------------------------------------------------------------------------
// layer_mac_sequencer
//
// Control FSM for one fully-connected layer. For every neuron it clears the
// accumulator, issues one MAC beat per input (plus an optional bias beat),
// requests activation, then writes the activated value to output slot
// out_idx. A single done pulse closes the pass.
//
// All state and outputs update on the falling edge of clk. Every output is a
// flop whose next value is decoded from the next state, so outputs change
// together with the state and never glitch.
//
// Optional feature macro: LAYER_BIAS_EN
//   defined   : one extra MAC beat per neuron with in_idx = N_IN, bias_sel = 1
//   undefined : bias_sel is constant 0, N_IN beats per neuron
//
// Ports:
//   clk       clock (negedge active)
//   rst       synchronous active-high reset
//   start     begin a layer pass (sampled only in IDLE)
//   mac_ack   MAC beat complete (counted only in MAC)
//   act_ack   activation result valid (counted only in ACT)
//   busy      pass in progress
//   done      one-cycle pulse at the end of a pass
//   acc_clr   clear accumulator
//   mac_req   request MAC beat for (out_idx, in_idx)
//   act_req   request activation of the accumulator
//   wr_en     write activated value to output slot out_idx
//   bias_sel  MAC operand is the bias rather than an input
//   in_idx    current input index
//   out_idx   current neuron index
// ---------------------------------------------------------------------------
module layer_mac_sequencer #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mac_ack,
    input  logic             act_ack,
    output logic             busy,
    output logic             done,
    output logic             acc_clr,
    output logic             mac_req,
    output logic             act_req,
    output logic             wr_en,
    output logic             bias_sel,
    output logic [IDX_W-1:0] in_idx,
    output logic [IDX_W-1:0] out_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MAC,
        S_ACT,
        S_WRITE,
        S_DONE
    } state_t;

`ifdef LAYER_BIAS_EN
    // The bias beat is one extra beat after the last real input.
    localparam int               LAST_BEAT = N_IN;
    localparam logic [IDX_W-1:0] BIAS_IDX  = IDX_W'(N_IN);
`else
    localparam int               LAST_BEAT = N_IN - 1;
`endif
    localparam logic [IDX_W-1:0] IN_LAST  = IDX_W'(LAST_BEAT);
    localparam logic [IDX_W-1:0] OUT_LAST = IDX_W'(N_OUT - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] in_idx_reg, in_idx_next;
    logic [IDX_W-1:0] out_idx_reg, out_idx_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             acc_clr_reg, acc_clr_next;
    logic             mac_req_reg, mac_req_next;
    logic             act_req_reg, act_req_next;
    logic             wr_en_reg, wr_en_next;
    logic             bias_sel_reg, bias_sel_next;

    always_ff @(negedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            in_idx_reg   <= '0;
            out_idx_reg  <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            acc_clr_reg  <= 1'b0;
            mac_req_reg  <= 1'b0;
            act_req_reg  <= 1'b0;
            wr_en_reg    <= 1'b0;
            bias_sel_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            in_idx_reg   <= in_idx_next;
            out_idx_reg  <= out_idx_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            acc_clr_reg  <= acc_clr_next;
            mac_req_reg  <= mac_req_next;
            act_req_reg  <= act_req_next;
            wr_en_reg    <= wr_en_next;
            bias_sel_reg <= bias_sel_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        in_idx_next  = in_idx_reg;
        out_idx_next = out_idx_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next   = S_CLR;
                    in_idx_next  = '0;
                    out_idx_next = '0;
                end
            end
            S_CLR: begin
                state_next  = S_MAC;
                in_idx_next = '0;
            end
            S_MAC: begin
                // No ack means stall: everything holds.
                if (mac_ack) begin
                    if (in_idx_reg < IN_LAST) begin
                        in_idx_next = in_idx_reg + 1'b1;
                    end else begin
                        state_next = S_ACT;
                    end
                end
            end
            S_ACT: begin
                if (act_ack) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (out_idx_reg == OUT_LAST) begin
                    state_next = S_DONE;
                end else begin
                    state_next   = S_CLR;
                    out_idx_next = out_idx_reg + 1'b1;
                    in_idx_next  = '0;
                end
            end
            S_DONE: begin
                state_next   = S_IDLE;
                in_idx_next  = '0;
                out_idx_next = '0;
            end
            default: begin
                state_next   = S_IDLE;
                in_idx_next  = '0;
                out_idx_next = '0;
            end
        endcase

        // Moore decode of the next state keeps the strobes mutually exclusive.
        busy_next    = (state_next != S_IDLE);
        done_next    = (state_next == S_DONE);
        acc_clr_next = (state_next == S_CLR);
        mac_req_next = (state_next == S_MAC);
        act_req_next = (state_next == S_ACT);
        wr_en_next   = (state_next == S_WRITE);
`ifdef LAYER_BIAS_EN
        bias_sel_next = (state_next == S_MAC) && (in_idx_next == BIAS_IDX);
`else
        bias_sel_next = 1'b0;
`endif
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign acc_clr  = acc_clr_reg;
    assign mac_req  = mac_req_reg;
    assign act_req  = act_req_reg;
    assign wr_en    = wr_en_reg;
    assign bias_sel = bias_sel_reg;
    assign in_idx   = in_idx_reg;
    assign out_idx  = out_idx_reg;

endmodule

// File: doc/layer_mac_sequencer.md
Name: layer_mac_sequencer

Overview:
Control FSM for one fully-connected layer of the network. It sequences the shared MAC unit over every (neuron, input) pair, then triggers the activation stage and the output write for each neuron. It sits between the network top (start/done) and the layer datapath, i.e. MAC, accumulator, activation and output register file. One accepted MAC ack equals one multiply-accumulate beat.

Parameters:
N_IN, 2, inputs per neuron (MAC beats per neuron), >=1
N_OUT, 2, neurons in the layer, >=1
IDX_W, 2, width of in_idx/out_idx; must hold max(N_IN, N_OUT-1)

Ports:
clk  input  1  clock; all state updates on falling edge
rst  input  1  reset, synchronous, active-high
start  input  1  begin one layer pass; sampled only in IDLE
mac_ack  input  1  MAC beat complete; counted only in MAC state
act_ack  input  1  activation result valid; counted only in ACT state
busy  output  1  pass in progress
done  output  1  one-cycle pulse at end of pass
acc_clr  output  1  clear accumulator
mac_req  output  1  request MAC beat for (out_idx, in_idx)
act_req  output  1  request activation of accumulator
wr_en  output  1  write activated value to output slot out_idx
bias_sel  output  1  MAC operand is bias, not input (see Optional Feature)
in_idx  output  IDX_W  current input index
out_idx  output  IDX_W  current neuron index

Behaviour:
- All outputs registered. Each output changes only on negedge clk, together with the state.
- Reset: rst=1 at a negedge puts the FSM in IDLE and drives every output and both indices to 0. This holds mid-pass too; the pass is abandoned and no done pulse is issued.
- States: IDLE, CLR, MAC, ACT, WRITE, DONE.
- IDLE: busy=0. start=1 -> CLR, with out_idx=0, in_idx=0, busy=1.
- CLR: acc_clr=1 for exactly one cycle, then -> MAC with mac_req=1 and in_idx=0.
- MAC: mac_req held high for the whole state.
  - Each negedge with mac_ack=1 completes one beat.
  - If in_idx < N_IN-1, in_idx increments and the FSM stays in MAC.
  - Otherwise -> ACT (mac_req=0, act_req=1).
  - mac_ack=0 is a stall: indices and outputs hold.
- ACT: act_req held high until act_ack=1 is sampled, then -> WRITE (act_req=0, wr_en=1).
- WRITE: wr_en=1 for one cycle.
  - If out_idx = N_OUT-1 -> DONE.
  - Otherwise out_idx increments, in_idx=0, -> CLR.
- DONE: done=1, busy=1 for one cycle, then -> IDLE with busy=0 and indices reset to 0.
- start while busy is ignored and never queued.
- mac_ack outside MAC and act_ack outside ACT are ignored.
- Only one of acc_clr/mac_req/act_req/wr_en/done is ever high in a cycle.
- Zero-stall pass length is N_OUT*(N_IN+3) cycles in CLR..WRITE, plus 1 cycle in DONE.
- Index arithmetic is unsigned, IDX_W bits. Terminal-count compares stop the indices, so they never wrap.

Optional Feature:
- Macro: LAYER_BIAS_EN.
- Defined: after the last input beat, MAC continues for one extra beat with in_idx=N_IN and bias_sel=1. ACT is entered only after that beat is acked. Per-neuron length becomes N_IN+4 cycles.
- Undefined: bias_sel is constant 0 and no extra beat is issued.

Test Plan:
- Reset: assert rst 2 cycles mid-MAC with mac_ack=0 -> next negedge all outputs 0, state IDLE; a subsequent start runs a full pass from out_idx=0.
- Zero-stall pass (N_IN=2, N_OUT=2, acks tied 1), start sampled at negedge e0 -> busy rises e1, acc_clr at e1/e6, wr_en at e5 (out_idx=0) and e10 (out_idx=1), done pulse at e11, busy=0 at e12; exactly 4 MAC beats counted.
- MAC stall: hold mac_ack=0 for 5 cycles on in_idx=1 -> mac_req stays high, in_idx stays 1, no ACT entry; release -> ACT next negedge.
- Activation stall: act_ack delayed 3 cycles -> act_req high for exactly 4 cycles, wr_en one cycle after ack.
- Stray handshakes: start pulses and mac_ack pulses during ACT/WRITE -> no extra beats, no restart, done count=1.
- With LAYER_BIAS_EN: N_IN=2 -> in_idx sequence 0,1,2 per neuron, bias_sel=1 only on idx 2, done at e13.
